uart_transmitter: RTL and testbench

8N1 UART transmitter clocked by the 16x baud clock, paired with the UART receiver on the same BRclk16 domain. It accepts bytes from the SRAM readback logic over a valid/ready handshake and serialises them LSB-first on UART_TX. A one-byte holding register lets frames go out back-to-back. It counts transmitted frames and raises an end flag after a programmed number of bytes.

---
 rtl/uart_transmitter.sv | 120 ++++++++++++
 tb/tb_uart_transmitter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1/8N2 UART transmitter on the 16x baud clock; define UART_TX_PARITY_EN to add an even-parity bit
module uart_transmitter #(
  parameter logic [18:0] sram_read_num = 19'd1024,
  parameter int          STOP_BITS     = 1
) (
  input  logic       BRclk16,
  input  logic       reset,
  input  logic [7:0] TX_data,
  input  logic       UART_write_en,
  output logic       UART_tx_ready,
  output logic       UART_TX,
  output logic       UART_busy,
  output logic       UART_end_flag
);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t      state, state_n;
  logic [3:0]  tick, tick_n;
  logic [2:0]  bit_idx, bit_n;
  logic        stop_cnt, stop_n;
  logic [7:0]  shifter, shifter_n, hold, hold_n;
  logic        hold_full, hold_full_n;
  logic [18:0] cnt, cnt_n;
  logic        end_int, end_int_n;
  logic        tx_n, wr, load, bit_end, last_stop;
  assign wr        = UART_write_en && UART_tx_ready;
  assign bit_end   = tick == 4'd15;
  assign last_stop = state == STOP && bit_end && stop_cnt == 1'(STOP_BITS - 1);
  // next-state, shifter reload, holding register and frame counter
  always_comb begin
    state_n   = state;
    tick_n    = tick + 4'd1;
    bit_n     = bit_idx;
    stop_n    = stop_cnt;
    load      = 1'b0;
    case (state)
      IDLE: begin
        tick_n = '0;
        if (hold_full) begin
          state_n = START;
          load    = 1'b1;
        end
      end
      START: if (bit_end) begin
        state_n = DATA;
        bit_n   = '0;
      end
      DATA: if (bit_end) begin
        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
          stop_n  = 1'b0;
        end else begin
          bit_n = bit_idx + 3'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) begin
        state_n = STOP;
        stop_n  = 1'b0;
      end
`endif
      STOP: if (last_stop) begin
        state_n = hold_full ? START : IDLE;
        load    = hold_full;
      end else if (bit_end) begin
        stop_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    shifter_n   = load ? hold : shifter;
`ifdef UART_TX_PARITY_EN
    tx_n        = state_n == START ? 1'b0 : state_n == DATA ? shifter_n[bit_n] : state_n == PARITY ? ^shifter_n : 1'b1;
`else
    tx_n        = state_n == START ? 1'b0 : state_n == DATA ? shifter_n[bit_n] : 1'b1;
`endif
    hold_n      = wr ? TX_data : hold;
    hold_full_n = wr || (hold_full && !load);
    cnt_n       = (last_stop && !end_int) ? cnt + 19'd1 : cnt;
    end_int_n   = end_int || cnt_n == sram_read_num;
  end
  // state and registered outputs; ready drops once a byte waits or the end count is hit
  always_ff @(posedge BRclk16) begin
    if (!reset) begin
      state         <= IDLE;
      tick          <= '0;
      bit_idx       <= '0;
      stop_cnt      <= 1'b0;
      shifter       <= '0;
      hold          <= '0;
      hold_full     <= 1'b0;
      cnt           <= '0;
      end_int       <= 1'b0;
      UART_end_flag <= 1'b0;
      UART_TX       <= 1'b1;
      UART_busy     <= 1'b0;
      UART_tx_ready <= 1'b0;
    end else begin
      state         <= state_n;
      tick          <= tick_n;
      bit_idx       <= bit_n;
      stop_cnt      <= stop_n;
      shifter       <= shifter_n;
      hold          <= hold_n;
      hold_full     <= hold_full_n;
      cnt           <= cnt_n;
      end_int       <= end_int_n;
      UART_end_flag <= end_int;
      UART_TX       <= tx_n;
      UART_busy     <= state_n != IDLE;
      UART_tx_ready <= !hold_full_n && !end_int_n;
    end
  end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: scoreboard bench for uart_transmitter (sram_read_num=4)
module tb_uart_transmitter;
  localparam int STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 10 + PAR + STOP_BITS - 1;
  localparam int FL = 16 * NB;
  logic       BRclk16 = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] TX_data = '0;
  logic       UART_write_en = 1'b0;
  logic       UART_tx_ready, UART_TX, UART_busy, UART_end_flag;
  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] exp_q[$];
  int         busy_run = 0;
  int         last_run = 0;
  int         mpos = -1;
  logic [11:0] sh;

  uart_transmitter #(.sram_read_num(19'd4), .STOP_BITS(STOP_BITS)) dut (
    .BRclk16(BRclk16), .reset(reset), .TX_data(TX_data), .UART_write_en(UART_write_en),
    .UART_tx_ready(UART_tx_ready), .UART_TX(UART_TX), .UART_busy(UART_busy), .UART_end_flag(UART_end_flag)
  );

  always #5 BRclk16 = ~BRclk16;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: decode each frame at mid-bit and compare against the queued byte
  always @(negedge BRclk16) begin
    logic [7:0]  b;
    logic [11:0] e;
    if (!reset) begin
      mpos = -1;
      exp_q.delete();
    end else if (mpos < 0) begin
      if (UART_TX === 1'b0) mpos = 0;
    end else begin
      mpos++;
      if (mpos % 16 == 8) begin
        sh[mpos / 16] = UART_TX;
        if (mpos / 16 == NB - 1) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_frame: got byte %02h expected no frame at %0t", sh[8:1], $time);
          end else begin
            b = exp_q.pop_front();
            e = '1;
            e[0] = 1'b0;
            e[8:1] = b;
            if (PAR == 1) e[9] = ^b;
            chk("frame", 32'(sh & ((12'd1 << NB) - 12'd1)), 32'(e & ((12'd1 << NB) - 12'd1)));
          end
          mpos = -1;
        end
      end
    end
  end

  // length of each uninterrupted busy run
  always @(negedge BRclk16) begin
    if (UART_busy === 1'b1) busy_run++;
    else begin
      if (busy_run != 0) last_run = busy_run;
      busy_run = 0;
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    UART_write_en = 1'b0;
    repeat (3) @(negedge BRclk16);
    chk("rst_tx", UART_TX, 1);
    chk("rst_busy", UART_busy, 0);
    chk("rst_ready", UART_tx_ready, 0);
    chk("rst_end", UART_end_flag, 0);
    reset = 1'b1;
    @(negedge BRclk16);
    chk("ready_after_release", UART_tx_ready, 1);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!UART_tx_ready && n < 600) begin
      @(negedge BRclk16);
      n++;
    end
    chk("send_ready_timeout", n < 600, 1);
    TX_data = b;
    UART_write_en = 1'b1;
    if (UART_tx_ready) exp_q.push_back(b);
    @(negedge BRclk16);
    UART_write_en = 1'b0;
  endtask

  task automatic drop(input logic [7:0] b);
    chk("drop_ready_low", UART_tx_ready, 0);
    TX_data = b;
    UART_write_en = 1'b1;
    @(negedge BRclk16);
    UART_write_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || UART_busy) && n < 3000) begin
      @(negedge BRclk16);
      n++;
    end
    chk("idle_timeout", n < 3000, 1);
    @(negedge BRclk16);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    do_reset();
    // single byte, latency and frame length
    send(8'h55);
    chk("lat_tx_before", UART_TX, 1);
    chk("lat_busy_before", UART_busy, 0);
    @(negedge BRclk16);
    chk("lat_tx_fall", UART_TX, 0);
    chk("lat_busy_rise", UART_busy, 1);
    wait_idle();
    chk("busy_len_single", last_run, FL);
    // back-to-back frames
    send(8'hA3);
    send(8'h0F);
    wait_idle();
    chk("busy_len_b2b", last_run, 2 * FL);
`ifdef UART_TX_PARITY_EN
    do_reset();
    send(8'hA3);
    send(8'h07);
    wait_idle();
    chk("busy_len_par", last_run, 2 * FL);
`endif
    // write while holding register full is dropped
    do_reset();
    send(8'h3C);
    send(8'hC5);
    drop(8'h77);
    wait_idle();
    repeat (200) @(negedge BRclk16);
    chk("drop_idle_busy", UART_busy, 0);
    // reset in the middle of a frame
    do_reset();
    send(8'hFF);
    repeat (70) @(negedge BRclk16);
    reset = 1'b0;
    @(negedge BRclk16);
    chk("midrst_tx", UART_TX, 1);
    chk("midrst_busy", UART_busy, 0);
    chk("midrst_ready", UART_tx_ready, 0);
    chk("midrst_end", UART_end_flag, 0);
    reset = 1'b1;
    @(negedge BRclk16);
    chk("midrst_ready_release", UART_tx_ready, 1);
    send(8'h01);
    wait_idle();
    chk("busy_len_after_rst", last_run, FL);
    // end flag after four frames
    do_reset();
    for (int i = 0; i < 4; i++) send(8'($urandom));
    chk("end_before", UART_end_flag, 0);
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge BRclk16);
      n++;
    end
    while (UART_busy && n < 1000) begin
      @(negedge BRclk16);
      n++;
    end
    chk("end_wait_timeout", n < 1000, 1);
    chk("end_at_stop_edge", UART_end_flag, 0);
    chk("ready_at_end", UART_tx_ready, 0);
    @(negedge BRclk16);
    chk("end_rise", UART_end_flag, 1);
    drop(8'($urandom));
    drop(8'($urandom));
    repeat (300) @(negedge BRclk16);
    chk("end_no_fifth", UART_busy, 0);
    chk("end_sticky", UART_end_flag, 1);
    chk("end_ready_low", UART_tx_ready, 0);
    // randomized rounds with dropped writes
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
        repeat ($urandom_range(0, 30)) @(negedge BRclk16);
        send(8'($urandom));
        if (!UART_tx_ready && $urandom_range(0, 1) == 1) drop(8'($urandom));
      end
      wait_idle();
      chk("rand_end_low", UART_end_flag, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
